// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 hex display: receiver states,
// the PS/2 break (key release) prefix and the seven-segment encoding.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;

  // Segment bit0=a ... bit6=g, active-high
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/ps2_hex_display_if.sv
// PS/2 line inputs and display/status outputs of the hex display.
// master = keyboard/host side, slave = display controller.
interface ps2_hex_display_if #(
  parameter int NUM_BYTES = 2
);
  logic                     SDA;
  logic                     SCL;
  logic [14*NUM_BYTES-1:0]  LED_SEG;
  logic                     DATA_VALID;
  logic [7:0]               RX_DATA;
  logic                     FRAME_ERR;

  modport master (output SDA, SCL, input LED_SEG, DATA_VALID, RX_DATA, FRAME_ERR);
  modport slave  (input SDA, SCL, output LED_SEG, DATA_VALID, RX_DATA, FRAME_ERR);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises SDA/SCL, detects SCL falling edges,
// walks start/data/parity/stop and aborts a stalled frame after a timeout.
// rx_valid/rx_err are single-cycle strobes on the cycle the STOP edge (or
// timeout) is seen; rx_byte is valid alongside rx_valid.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sda,
  input  logic       scl,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sda_sync, scl_sync;
  logic                   scl_prev;
  logic                   sda_s, scl_s, fall;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par, par_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;

  // Synchronisers reset high so an idle bus never looks like a falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_sync <= '1;
      scl_sync <= '1;
      scl_prev <= 1'b1;
    end else begin
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      scl_prev <= scl_s;
    end
  end

  assign sda_s   = sda_sync[SYNC_STAGES-1];
  assign scl_s   = scl_sync[SYNC_STAGES-1];
  assign fall    = scl_prev & ~scl_s;
  assign rx_byte = shreg;

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      tcnt    <= tcnt_nxt;
    end
  end

  // Next-state, shifting, frame checks and stall timeout
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_nxt     = par;
    tcnt_nxt    = '0;
    rx_valid    = 1'b0;
    rx_err      = 1'b0;

    if (state != IDLE && !fall) tcnt_nxt = tcnt + 1'b1;

    case (state)
      IDLE: if (fall && !sda_s) begin
        state_nxt   = DATA;
        bit_cnt_nxt = '0;
      end
      DATA: if (fall) begin
        shreg_nxt   = {sda_s, shreg[7:1]};
        bit_cnt_nxt = bit_cnt + 1'b1;
        if (bit_cnt == 3'd7) state_nxt = PARITY;
      end
      PARITY: if (fall) begin
        par_nxt   = sda_s;
        state_nxt = STOP;
      end
      STOP: if (fall) begin
        state_nxt = IDLE;
        if (sda_s && (^{shreg, par})) rx_valid = 1'b1;
        else                          rx_err   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // A real edge wins over an expiring timer on the same cycle
    if (state != IDLE && !fall && tcnt == T_LAST) begin
      state_nxt = IDLE;
      tcnt_nxt  = '0;
      rx_err    = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_hex_display.sv
// PS/2 keyboard hex display: keeps the last NUM_BYTES good bytes and shows
// them on 2*NUM_BYTES seven-segment digits (byte 0 on digits 1:0).
// Optional build macro PS2_BREAK_FILTER_EN drops the 0xF0 release prefix
// and the key code that follows it.
module ps2_hex_display
  import ps2_pkg::*;
#(
  parameter int NUM_BYTES      = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int RESET_DIGIT    = 5
) (
  input logic              CLOCK,
  input logic              RESET,
  ps2_hex_display_if.slave bus
);

  localparam logic [3:0] RST_NIB = RESET_DIGIT[3:0];

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err, accept;
  logic [7:0] hist [NUM_BYTES];
  logic [7:0] rx_data_q;
  logic       data_valid_q, frame_err_q;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (CLOCK),
    .rst     (RESET),
    .sda     (bus.SDA),
    .scl     (bus.SCL),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

`ifdef PS2_BREAK_FILTER_EN
  logic brk_flag;

  // Release prefix arms the flag; the next good byte or any error disarms it
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)         brk_flag <= 1'b0;
    else if (rx_err)   brk_flag <= 1'b0;
    else if (rx_valid) brk_flag <= !brk_flag && (rx_byte == BREAK_CODE);
  end

  assign accept = rx_valid && !brk_flag && (rx_byte != BREAK_CODE);
`else
  assign accept = rx_valid;
`endif

  // History shift register and registered status outputs
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_BYTES; i++) hist[i] <= {RST_NIB, RST_NIB};
      rx_data_q    <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_valid_q <= accept;
      frame_err_q  <= rx_err;
      if (accept) begin
        for (int i = NUM_BYTES - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0]   <= rx_byte;
        rx_data_q <= rx_byte;
      end
    end
  end

  assign bus.RX_DATA    = rx_data_q;
  assign bus.DATA_VALID = data_valid_q;
  assign bus.FRAME_ERR  = frame_err_q;

  for (genvar k = 0; k < 2*NUM_BYTES; k++) begin : g_digit
    assign bus.LED_SEG[7*k +: 7] = hex_to_seg(hist[k/2][4*(k%2) +: 4]);
  end

endmodule
